pipeline_run_controller: RTL and testbench



---
 rtl/pipeline_run_controller.sv | 93 +++++++++
 tb/tb_pipeline_run_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller: host-driven run/step/breakpoint sequencer producing the pipeline clock-enable.
module pipeline_run_controller #(
  parameter int          PC_WIDTH    = 11,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_empty,
  input  logic [7:0]             rx_data,
  output logic                   rx_rd,
  input  logic [PC_WIDTH-1:0]    current_pc,
  input  logic [31:0]            instruction,
  input  logic                   dump_done,
  output logic                   pipe_enable,
  output logic                   dump_start,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic                   bp_hit,
  output logic                   halted,
  output logic [2:0]             state_out
);
  typedef enum logic [2:0] {IDLE = 3'd0, BP_LO = 3'd1, BP_HI = 3'd2, RUN = 3'd3, STEP = 3'd4, DUMP = 3'd5, DONE = 3'd6} state_t;
  localparam logic [7:0] CH_B = 8'h62, CH_C = 8'h63, CH_D = 8'h64, CH_H = 8'h68, CH_R = 8'h72, CH_S = 8'h73;
  state_t                  state_q, state_d;
  logic [PC_WIDTH-1:0]     bp_addr_q, bp_addr_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    bp_valid_q, bp_valid_d, halted_q, halted_d, bp_hit_q, bp_hit_d;
  logic                    first_q, first_d, dump_start_q, dump_start_d;
  logic                    byte_v, halt_m, bp_m, h_m, stop, idle_byte;
  assign byte_v    = !rx_empty;
  assign halt_m    = instruction == HALT_WORD;
  assign bp_m      = bp_valid_q && current_pc == bp_addr_q && !first_q;
  assign h_m       = byte_v && rx_data == CH_H;
  assign stop      = state_q == RUN && (halt_m || bp_m || h_m);
  assign idle_byte = state_q == IDLE && byte_v;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (byte_v) state_d = rx_data == CH_C ? RUN : rx_data == CH_S ? STEP : rx_data == CH_B ? BP_LO : rx_data == CH_D ? DUMP : IDLE;
      BP_LO:   if (byte_v) state_d = BP_HI;
      BP_HI:   if (byte_v) state_d = IDLE;
      RUN:     if (stop) state_d = DUMP;
      STEP:    state_d = DUMP;
      DUMP:    if (dump_done) state_d = halted_q ? DONE : IDLE;
      DONE:    if (byte_v && rx_data == CH_D) state_d = DUMP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    pipe_enable = (state_q == RUN && !stop) || state_q == STEP;
    rx_rd       = (byte_v && (state_q == IDLE || state_q == BP_LO || state_q == BP_HI || state_q == DONE)) ||
                  (state_q == RUN && h_m && !halt_m && !bp_m);
  end
  always_comb begin
    bp_addr_d    = state_q == BP_LO && byte_v ? {bp_addr_q[PC_WIDTH-1:8], rx_data} :
                   state_q == BP_HI && byte_v ? {rx_data[PC_WIDTH-9:0], bp_addr_q[7:0]} : bp_addr_q;
    bp_valid_d   = bp_valid_q || (state_q == BP_HI && byte_v);
    halted_d     = halted_q || (stop && halt_m);
    bp_hit_d     = (bp_hit_q && !idle_byte) || (stop && !halt_m && bp_m);
    count_d      = idle_byte && rx_data == CH_R ? '0 : pipe_enable && !(&count_q) ? count_q + 1'b1 : count_q;
    // first marks the entry cycle so a resumed run may leave the breakpoint PC
    first_d      = state_d == RUN && state_q != RUN;
    dump_start_d = state_d == DUMP && state_q != DUMP;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bp_addr_q    <= '0;
      bp_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
      bp_hit_q     <= 1'b0;
      count_q      <= '0;
      first_q      <= 1'b0;
      dump_start_q <= 1'b0;
    end else begin
      bp_addr_q    <= bp_addr_d;
      bp_valid_q   <= bp_valid_d;
      halted_q     <= halted_d;
      bp_hit_q     <= bp_hit_d;
      count_q      <= count_d;
      first_q      <= first_d;
      dump_start_q <= dump_start_d;
    end
  end
  assign dump_start  = dump_start_q;
  assign cycle_count = count_q;
  assign bp_hit      = bp_hit_q;
  assign halted      = halted_q;
  assign state_out   = state_q;
endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb_pipeline_run_controller: directed and random host sessions against a byte-queue / PC-counter reference model.
module tb_pipeline_run_controller;
  localparam int          PW = 11;
  localparam int          CW = 6;
  localparam logic [31:0] HW = 32'hFFFF_FFFF;
  logic          clock = 0, reset = 1, rx_empty = 1, dump_done = 0;
  logic [7:0]    rx_data = 0;
  logic [PW-1:0] current_pc = 0;
  logic [31:0]   instruction = 0;
  logic          rx_rd, pipe_enable, dump_start, bp_hit, halted;
  logic [CW-1:0] cycle_count;
  logic [2:0]    state_out;
  pipeline_run_controller #(.PC_WIDTH(PW), .HALT_WORD(HW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
    .current_pc(current_pc), .instruction(instruction), .dump_done(dump_done),
    .pipe_enable(pipe_enable), .dump_start(dump_start), .cycle_count(cycle_count),
    .bp_hit(bp_hit), .halted(halted), .state_out(state_out));
  always #5 clock = ~clock;
  int            checks = 0, failures = 0;
  logic [7:0]    q[$];
  logic [PW-1:0] pc = 0;
  int            halt_pc = -1, dd_timer = 0, ds_pulses = 0, en_cycles = 0;
  bit            rand_mode = 0;
  int            m_st = 0, m_cnt = 0;
  logic [PW-1:0] m_bpa = 0;
  bit            m_bpv = 0, m_halt = 0, m_hit = 0, m_first = 0, m_ds = 0, m_en = 0, m_rd = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive();
    rx_empty    = q.size() == 0;
    rx_data     = rx_empty ? 8'h00 : q[0];
    current_pc  = pc;
    instruction = (halt_pc >= 0 && int'(pc) == halt_pc) ? HW : ($urandom & 32'h7FFF_FFFF);
  endtask
  task automatic push(input logic [7:0] b);
    q.push_back(b);
    drive();
  endtask
  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_bpa = 0; m_bpv = 0; m_halt = 0; m_hit = 0; m_first = 0; m_ds = 0;
  endtask
  task automatic step();
    bit            have, hmatch, bpm, hb, run, stop, cur_ds, nbpv, nhalt, nhit;
    logic [7:0]    b;
    int            nst, ncnt;
    logic [PW-1:0] nbpa;
    @(negedge clock);
    have   = q.size() > 0;
    b      = have ? q[0] : 8'h00;
    hmatch = halt_pc >= 0 && int'(pc) == halt_pc;
    bpm    = m_bpv && pc == m_bpa && !m_first;
    hb     = have && b == 8'h68;
    run    = m_st == 3;
    stop   = run && (hmatch || bpm || hb);
    m_en   = (run && !stop) || m_st == 4;
    m_rd   = have && (m_st == 0 || m_st == 1 || m_st == 2 || m_st == 6 || (run && hb && !hmatch && !bpm));
    chk("state_out", 32'(state_out), 32'(m_st));
    chk("pipe_enable", 32'(pipe_enable), 32'(m_en));
    chk("rx_rd", 32'(rx_rd), 32'(m_rd));
    chk("dump_start", 32'(dump_start), 32'(m_ds));
    chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
    chk("bp_hit", 32'(bp_hit), 32'(m_hit));
    chk("halted", 32'(halted), 32'(m_halt));
    if (dump_start === 1'b1) ds_pulses++;
    if (pipe_enable === 1'b1) en_cycles++;
    nst = m_st; ncnt = m_cnt; nbpa = m_bpa; nbpv = m_bpv; nhalt = m_halt; nhit = m_hit;
    if (m_st == 0 && have) begin
      nhit = 0;
      if (b == 8'h63) nst = 3;
      else if (b == 8'h73) nst = 4;
      else if (b == 8'h62) nst = 1;
      else if (b == 8'h64) nst = 5;
      else if (b == 8'h72) ncnt = 0;
    end else if (m_st == 1 && have) begin
      nbpa[7:0] = b; nst = 2;
    end else if (m_st == 2 && have) begin
      nbpa[PW-1:8] = b[2:0]; nbpv = 1; nst = 0;
    end else if (stop) begin
      nst = 5;
      if (hmatch) nhalt = 1;
      else if (bpm) nhit = 1;
    end else if (m_st == 4) nst = 5;
    else if (m_st == 5 && dump_done) nst = m_halt ? 6 : 0;
    else if (m_st == 6 && have && b == 8'h64) nst = 5;
    if (m_en && ncnt < (1 << CW) - 1) ncnt++;
    @(posedge clock); #1;
    cur_ds  = m_ds;
    m_first = nst == 3 && m_st != 3;
    m_ds    = nst == 5 && m_st != 5;
    m_st = nst; m_cnt = ncnt; m_bpa = nbpa; m_bpv = nbpv; m_halt = nhalt; m_hit = nhit;
    if (m_rd) void'(q.pop_front());
    if (m_en) pc++;
    if (cur_ds) dd_timer = 5;
    dump_done = 0;
    if (dd_timer > 0) begin
      dd_timer--;
      if (dd_timer == 0) dump_done = 1;
    end else if (rand_mode && $urandom_range(0, 40) == 0) dump_done = 1;
    drive();
  endtask
  task automatic check_zero(input string tag);
    chk({tag, ".state"}, 32'(state_out), 0);
    chk({tag, ".pipe_enable"}, 32'(pipe_enable), 0);
    chk({tag, ".rx_rd"}, 32'(rx_rd), 0);
    chk({tag, ".dump_start"}, 32'(dump_start), 0);
    chk({tag, ".cycle_count"}, 32'(cycle_count), 0);
    chk({tag, ".bp_hit"}, 32'(bp_hit), 0);
    chk({tag, ".halted"}, 32'(halted), 0);
  endtask
  task automatic do_reset();
    q.delete(); halt_pc = -1; pc = 0; dd_timer = 0; dump_done = 0;
    drive();
    @(negedge clock); #2;
    reset = 1; #1;
    check_zero("reset");
    model_reset();
    @(posedge clock); #1;
    reset = 0;
    ds_pulses = 0; en_cycles = 0;
    drive();
  endtask
  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (m_st != target && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (m_st == target) else begin
      failures++;
      $error("FAIL run_until state=%0d target=%0d after %0d cycles", m_st, target, n);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic [7:0] pick;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(8'h73);
      run_until(5, 10);
      run_until(0, 20);
    end
    chk("step.count", 32'(cycle_count), 3);
    chk("step.ds_pulses", 32'(ds_pulses), 3);
    chk("step.en_cycles", 32'(en_cycles), 3);
    chk("step.state", 32'(state_out), 0);
    do_reset();
    push(8'h62); push(8'h10); push(8'h00); push(8'h63);
    run_until(5, 60);
    chk("bp.pc", 32'(pc), 16);
    chk("bp.count", 32'(cycle_count), 16);
    chk("bp.hit", 32'(bp_hit), 1);
    run_until(0, 20);
    push(8'h63);
    repeat (10) step();
    chk("bp.resume_state", 32'(state_out), 3);
    chk("bp.resume_past", 32'(pc > 16), 1);
    chk("bp.hit_cleared", 32'(bp_hit), 0);
    push(8'h68); push(8'h78);
    step();
    chk("h.state", 32'(state_out), 5);
    chk("h.x_kept", 32'(q.size()), 1);
    run_until(0, 20);
    step();
    chk("x.discarded", 32'(q.size()), 0);
    chk("x.idle", 32'(state_out), 0);
    do_reset();
    halt_pc = 5;
    drive();
    push(8'h63);
    run_until(5, 30);
    chk("halt.halted", 32'(halted), 1);
    chk("halt.pc", 32'(pc), 5);
    chk("halt.count", 32'(cycle_count), 5);
    run_until(6, 20);
    push(8'h63);
    step(); step();
    chk("done.c_ignored", 32'(state_out), 6);
    chk("done.c_popped", 32'(q.size()), 0);
    n = ds_pulses;
    push(8'h64);
    run_until(5, 5);
    run_until(6, 20);
    chk("done.redump", 32'(ds_pulses), n + 1);
    do_reset();
    push(8'h62); push(8'h07); push(8'h00);
    halt_pc = 7;
    push(8'h63);
    run_until(5, 30);
    chk("tie.halted", 32'(halted), 1);
    chk("tie.bp_hit", 32'(bp_hit), 0);
    do_reset();
    push(8'h62); push(8'h3C); push(8'h00); push(8'h63);
    n = 0;
    while (m_cnt < 40 && n < 200) begin step(); n++; end
    chk("rst.count40", 32'(cycle_count), 40);
    #2 reset = 1; #1;
    check_zero("midrun");
    model_reset();
    dd_timer = 0;
    @(posedge clock); #1;
    reset = 0;
    drive();
    push(8'h63);
    repeat (30) step();
    chk("rst.no_bp_state", 32'(state_out), 3);
    chk("rst.past_bp", 32'(pc > 60), 1);
    repeat (40) step();
    chk("sat.count", 32'(cycle_count), 63);
    push(8'h68);
    run_until(5, 5);
    rand_mode = 1;
    for (int s = 0; s < 6; s++) begin
      do_reset();
      halt_pc = $urandom_range(0, 3) == 0 ? int'($urandom_range(10, 150)) : -1;
      drive();
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 7) == 0 && q.size() < 4) begin
          case ($urandom_range(0, 9))
            0, 1: push(8'h63);
            2: push(8'h73);
            3: begin
              pick = pc[7:0] + 8'($urandom_range(1, 30));
              push(8'h62); push(pick); push({5'b0, pc[10:8]});
            end
            4: push(8'h64);
            5: push(8'h72);
            6, 7: push(8'h68);
            8: push(8'h78);
            default: push(8'($urandom));
          endcase
        end
        step();
      end
    end
    rand_mode = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
